// File: rtl/cache_modport.sv
// cache_modport: set-associative, write-back data cache with one-byte
// processor accesses and Dragon update-protocol line states.
//
// Ports
//   clock, reset          single clock; asynchronous active-high reset
//   pr_req/pr_rnw         processor request (sampled in IDLE), 1=read 0=write
//   pr_addr/pr_wdata      byte address {tag, index, byteselect[1:0]}, write byte
//   pr_rdata/pr_done      read byte and one-cycle completion pulse
//   hit/miss/stall        lookup result (held until IDLE) and busy flag
//   mem_addr/mem_wdata    block address (byteselect=00) and writeback block
//   mem_we/mem_rdata      writeback strobe, combinational fill data
//   bus_rd/bus_upd        Dragon BusRd / BusUpd strobes
//   shared                another cache holds the block (sampled in SEND/WRCACHE)
module cache_modport #(
  parameter  int INDEXBITS     = 4,
  parameter  int TAGBITS       = 10,
  parameter  int ASSOCIATIVITY = 4,
  parameter  int BLOCKBYTES    = 4,
  localparam int ADDRESSWIDTH  = TAGBITS + INDEXBITS + 2,
  localparam int DATABUSWIDTH  = 8 * BLOCKBYTES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pr_req,
  input  logic                    pr_rnw,
  input  logic [ADDRESSWIDTH-1:0] pr_addr,
  input  logic [7:0]              pr_wdata,
  output logic [7:0]              pr_rdata,
  output logic                    pr_done,
  output logic                    hit,
  output logic                    miss,
  output logic                    stall,
  output logic [ADDRESSWIDTH-1:0] mem_addr,
  output logic [DATABUSWIDTH-1:0] mem_wdata,
  output logic                    mem_we,
  input  logic [DATABUSWIDTH-1:0] mem_rdata,
  output logic                    bus_rd,
  output logic                    bus_upd,
  input  logic                    shared
);

  localparam int SETS    = 2 ** INDEXBITS;
  localparam int WAYBITS = (ASSOCIATIVITY > 1) ? $clog2(ASSOCIATIVITY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_EVICT, S_WRMEM, S_RDMEM, S_SEND, S_WRCACHE
  } fsm_t;

  typedef enum logic [1:0] {
    D_EXCL, D_SHCLEAN, D_SHMOD, D_DIRTY
  } dragon_t;

  fsm_t                    fsm_q, fsm_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic                    rnw_q, rnw_d;
  logic [7:0]              wdata_q, wdata_d;
  logic [WAYBITS-1:0]      way_q, way_d;     // hit way or chosen victim
  logic                    hit_q, hit_d;
  logic                    miss_q, miss_d;

  logic                    valid_q  [SETS][ASSOCIATIVITY];
  logic [TAGBITS-1:0]      tag_q    [SETS][ASSOCIATIVITY];
  dragon_t                 dstate_q [SETS][ASSOCIATIVITY];
  logic [DATABUSWIDTH-1:0] data_q   [SETS][ASSOCIATIVITY];
  // lru_q[set][0] is the LRU way, lru_q[set][ASSOCIATIVITY-1] the MRU way
  logic [WAYBITS-1:0]      lru_q    [SETS][ASSOCIATIVITY];

  logic [TAGBITS-1:0]   req_tag;
  logic [INDEXBITS-1:0] req_idx;
  logic [1:0]           req_bsel;
  assign req_tag  = addr_q[ADDRESSWIDTH-1 -: TAGBITS];
  assign req_idx  = addr_q[INDEXBITS+1:2];
  assign req_bsel = addr_q[1:0];

  // Tag lookup and invalid-way search; scanning downward makes the lowest way win
  logic               match_any, inv_any;
  logic [WAYBITS-1:0] match_way, inv_way, victim_way;
  logic               victim_dirty;
  always_comb begin
    match_any = 1'b0;
    match_way = '0;
    inv_any   = 1'b0;
    inv_way   = '0;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        match_any = 1'b1;
        match_way = WAYBITS'(w);
      end
      if (!valid_q[req_idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAYBITS'(w);
      end
    end
  end

  assign victim_way   = inv_any ? inv_way : lru_q[req_idx][0];
  assign victim_dirty = valid_q[req_idx][victim_way] &&
                        ((dstate_q[req_idx][victim_way] == D_DIRTY) ||
                         (dstate_q[req_idx][victim_way] == D_SHMOD));

  // Dragon transitions for the accessed line
  dragon_t cur_dstate, new_dstate;
  logic    upd_needed;
  assign cur_dstate = dstate_q[req_idx][way_q];
  // A write to a freshly filled line or to a shared line must broadcast BusUpd
  assign upd_needed = miss_q || (cur_dstate == D_SHCLEAN) || (cur_dstate == D_SHMOD);

  always_comb begin
    new_dstate = cur_dstate;
    if (fsm_q == S_SEND) begin
      if (miss_q) new_dstate = shared ? D_SHCLEAN : D_EXCL;
    end else if (fsm_q == S_WRCACHE) begin
      new_dstate = (upd_needed && shared) ? D_SHMOD : D_DIRTY;
    end
  end

  // LRU: the accessed way moves to MRU; entries after its old slot shift down
  logic [WAYBITS-1:0] lru_shift [ASSOCIATIVITY];
  logic [WAYBITS-1:0] lru_new   [ASSOCIATIVITY];
  logic               lru_found;
  generate
    for (genvar gi = 0; gi < ASSOCIATIVITY - 1; gi++) begin : g_lru_shift
      assign lru_shift[gi] = lru_q[req_idx][gi+1];
    end
  endgenerate
  assign lru_shift[ASSOCIATIVITY-1] = way_q;

  always_comb begin
    lru_found = 1'b0;
    for (int p = 0; p < ASSOCIATIVITY; p++) begin
      if (lru_q[req_idx][p] == way_q) lru_found = 1'b1;
      lru_new[p] = lru_found ? lru_shift[p] : lru_q[req_idx][p];
    end
  end

  // Next-state logic
  always_comb begin
    fsm_d   = fsm_q;
    addr_d  = addr_q;
    rnw_d   = rnw_q;
    wdata_d = wdata_q;
    way_d   = way_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    case (fsm_q)
      S_IDLE: begin
        if (pr_req) begin
          addr_d  = pr_addr;
          rnw_d   = pr_rnw;
          wdata_d = pr_wdata;
          fsm_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        hit_d  = match_any;
        miss_d = !match_any;
        if (match_any) begin
          way_d = match_way;
          fsm_d = rnw_q ? S_SEND : S_WRCACHE;
        end else begin
          fsm_d = S_EVICT;
        end
      end
      S_EVICT: begin
        way_d = victim_way;
        fsm_d = victim_dirty ? S_WRMEM : S_RDMEM;
      end
      S_WRMEM: fsm_d = S_RDMEM;
      S_RDMEM: fsm_d = rnw_q ? S_SEND : S_WRCACHE;
      S_SEND, S_WRCACHE: begin
        fsm_d  = S_IDLE;
        hit_d  = 1'b0;
        miss_d = 1'b0;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Control and line-state flops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q   <= S_IDLE;
      addr_q  <= '0;
      rnw_q   <= 1'b0;
      wdata_q <= '0;
      way_q   <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
          valid_q[s][w]  <= 1'b0;
          dstate_q[s][w] <= D_EXCL;
          lru_q[s][w]    <= WAYBITS'(w);
        end
      end
    end else begin
      fsm_q   <= fsm_d;
      addr_q  <= addr_d;
      rnw_q   <= rnw_d;
      wdata_q <= wdata_d;
      way_q   <= way_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      if (fsm_q == S_RDMEM) begin
        valid_q[req_idx][way_q]  <= 1'b1;
        dstate_q[req_idx][way_q] <= D_EXCL;  // refined in SEND/WRCACHE
      end
      if ((fsm_q == S_SEND) || (fsm_q == S_WRCACHE)) begin
        dstate_q[req_idx][way_q] <= new_dstate;
        for (int p = 0; p < ASSOCIATIVITY; p++) lru_q[req_idx][p] <= lru_new[p];
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use
  always_ff @(posedge clock) begin
    if (fsm_q == S_RDMEM) begin
      tag_q[req_idx][way_q]  <= req_tag;
      data_q[req_idx][way_q] <= mem_rdata;
    end else if (fsm_q == S_WRCACHE) begin
      data_q[req_idx][way_q][8*req_bsel +: 8] <= wdata_q;
    end
  end

  // Outputs decoded from the registered state
  assign stall   = (fsm_q != S_IDLE);
  assign hit     = hit_q  || ((fsm_q == S_CHECK) &&  match_any);
  assign miss    = miss_q || ((fsm_q == S_CHECK) && !match_any);
  assign pr_done = (fsm_q == S_SEND) || (fsm_q == S_WRCACHE);
  assign pr_rdata = (fsm_q == S_SEND) ? data_q[req_idx][way_q][8*req_bsel +: 8] : 8'h00;
  assign mem_we  = (fsm_q == S_WRMEM);
  assign bus_rd  = (fsm_q == S_RDMEM);
  assign bus_upd = (fsm_q == S_WRCACHE) && upd_needed;
  assign mem_wdata = (fsm_q == S_WRMEM) ? data_q[req_idx][way_q] : '0;

  always_comb begin
    mem_addr = '0;
    if (fsm_q == S_WRMEM)      mem_addr = {tag_q[req_idx][way_q], req_idx, 2'b00};
    else if (fsm_q == S_RDMEM) mem_addr = {req_tag, req_idx, 2'b00};
  end

endmodule

// File: tb/tb_cache_modport.sv
// tb_cache_modport: directed, table-driven check of cache_modport with a
// behavioural backing memory.
module tb_cache_modport;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pr_req = 1'b0, pr_rnw = 1'b0;
  logic [AW-1:0] pr_addr = '0;
  logic [7:0]    pr_wdata = '0;
  logic [7:0]    pr_rdata;
  logic          pr_done, hit, miss, stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, bus_rd, bus_upd;
  logic          shared = 1'b0;

  cache_modport dut (
    .clock(clock), .reset(reset), .pr_req(pr_req), .pr_rnw(pr_rnw),
    .pr_addr(pr_addr), .pr_wdata(pr_wdata), .pr_rdata(pr_rdata),
    .pr_done(pr_done), .hit(hit), .miss(miss), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .bus_rd(bus_rd), .bus_upd(bus_upd),
    .shared(shared)
  );

  always #5 clock = ~clock;

  // Backing memory: untouched blocks follow a fixed pattern
  function automatic logic [31:0] pat(input logic [13:0] b);
    if (b == 14'd4) return 32'hDDCCBBAA;
    return {8'hEE, 8'h77, 2'b00, b[13:8], b[7:0]};
  endfunction

  bit          mem_written [16384];
  logic [31:0] mem_data    [16384];
  int          we_total = 0;

  always_comb begin
    mem_rdata = mem_written[mem_addr[15:2]] ? mem_data[mem_addr[15:2]] : pat(mem_addr[15:2]);
  end

  always @(posedge clock) begin
    if (mem_we) begin
      mem_written[mem_addr[15:2]] <= 1'b1;
      mem_data[mem_addr[15:2]]    <= mem_wdata;
      we_total                    <= we_total + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rnw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        shr;
    logic        exp_hit;
    int          exp_lat;
    logic [7:0]  exp_rdata;
    int          exp_rd;
    int          exp_we;
    logic [15:0] exp_we_addr;
    logic [31:0] exp_we_data;
    int          exp_upd;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic rnw, input logic [15:0] addr, input logic [7:0] wdata,
                              input logic shr, input logic exp_hit, input int exp_lat,
                              input logic [7:0] exp_rdata, input int exp_rd, input int exp_we,
                              input logic [15:0] exp_we_addr, input logic [31:0] exp_we_data,
                              input int exp_upd);
    vec_t v;
    v.rnw = rnw; v.addr = addr; v.wdata = wdata; v.shr = shr; v.exp_hit = exp_hit;
    v.exp_lat = exp_lat; v.exp_rdata = exp_rdata; v.exp_rd = exp_rd; v.exp_we = exp_we;
    v.exp_we_addr = exp_we_addr; v.exp_we_data = exp_we_data; v.exp_upd = exp_upd;
    return v;
  endfunction

  // Issues one request starting at a falling edge with the cache idle and
  // returns at a falling edge with the cache idle again.
  task automatic run_tx(input int k);
    vec_t        v;
    int          lat, rd_cnt, we_cnt, upd_cnt;
    logic [7:0]  rdata;
    logic        saw_hit, saw_miss;
    logic [15:0] we_addr, rd_addr;
    logic [31:0] we_data;
    v = vecs[k];
    lat = 0; rd_cnt = 0; we_cnt = 0; upd_cnt = 0;
    rdata = '0; saw_hit = 1'b0; saw_miss = 1'b0;
    we_addr = '0; rd_addr = '0; we_data = '0;
    pr_req = 1'b1; pr_rnw = v.rnw; pr_addr = v.addr; pr_wdata = v.wdata; shared = v.shr;
    @(posedge clock);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      pr_req = 1'b0;
      if (n == 1) begin saw_hit = hit; saw_miss = miss; end
      if (bus_rd)  begin rd_cnt++; rd_addr = mem_addr; end
      if (mem_we)  begin we_cnt++; we_addr = mem_addr; we_data = mem_wdata; end
      if (bus_upd) upd_cnt++;
      if (pr_done) begin lat = n; rdata = pr_rdata; break; end
    end
    @(negedge clock);
    check($sformatf("v%0d hit", k), 32'(saw_hit), 32'(v.exp_hit));
    check($sformatf("v%0d miss", k), 32'(saw_miss), 32'(!v.exp_hit));
    check($sformatf("v%0d latency", k), lat, v.exp_lat);
    if (v.rnw) check($sformatf("v%0d rdata", k), 32'(rdata), 32'(v.exp_rdata));
    check($sformatf("v%0d bus_rd count", k), rd_cnt, v.exp_rd);
    if (v.exp_rd > 0) check($sformatf("v%0d rd addr", k), 32'(rd_addr), 32'({v.addr[15:2], 2'b00}));
    check($sformatf("v%0d mem_we count", k), we_cnt, v.exp_we);
    if (v.exp_we > 0) begin
      check($sformatf("v%0d wb addr", k), 32'(we_addr), 32'(v.exp_we_addr));
      check($sformatf("v%0d wb data", k), we_data, v.exp_we_data);
    end
    check($sformatf("v%0d bus_upd count", k), upd_cnt, v.exp_upd);
    check($sformatf("v%0d idle stall", k), 32'(stall), 32'd0);
    $display("tx %0d: %s addr=%h hit=%0d lat=%0d rdata=%h rd=%0d we=%0d upd=%0d",
             k, v.rnw ? "RD" : "WR", v.addr, saw_hit, lat, rdata, rd_cnt, we_cnt, upd_cnt);
  endtask

  int we_before;

  initial begin
    //            rnw  addr     wd     sh hit lat rdata  rd we wbaddr   wbdata        upd
    vecs[0]  = mk(1, 16'h0010, 8'h00, 0, 0, 4, 8'hAA, 1, 0, 16'h0000, 32'h00000000, 0);
    vecs[1]  = mk(1, 16'h0011, 8'h00, 0, 1, 2, 8'hBB, 0, 0, 16'h0000, 32'h00000000, 0);
    vecs[2]  = mk(0, 16'h0012, 8'h55, 0, 1, 2, 8'h00, 0, 0, 16'h0000, 32'h00000000, 0);
    vecs[3]  = mk(1, 16'h0012, 8'h00, 0, 1, 2, 8'h55, 0, 0, 16'h0000, 32'h00000000, 0);
    vecs[4]  = mk(1, 16'h0050, 8'h00, 0, 0, 4, 8'h14, 1, 0, 16'h0000, 32'h00000000, 0);
    vecs[5]  = mk(1, 16'h0090, 8'h00, 0, 0, 4, 8'h24, 1, 0, 16'h0000, 32'h00000000, 0);
    vecs[6]  = mk(1, 16'h00D0, 8'h00, 0, 0, 4, 8'h34, 1, 0, 16'h0000, 32'h00000000, 0);
    vecs[7]  = mk(1, 16'h0110, 8'h00, 0, 0, 5, 8'h44, 1, 1, 16'h0010, 32'hDD55BBAA, 0);
    vecs[8]  = mk(1, 16'h0012, 8'h00, 0, 0, 4, 8'h55, 1, 0, 16'h0000, 32'h00000000, 0);
    vecs[9]  = mk(1, 16'h0014, 8'h00, 1, 0, 4, 8'h05, 1, 0, 16'h0000, 32'h00000000, 0);
    vecs[10] = mk(0, 16'h0015, 8'h77, 1, 1, 2, 8'h00, 0, 0, 16'h0000, 32'h00000000, 1);
    vecs[11] = mk(0, 16'h0016, 8'h88, 0, 1, 2, 8'h00, 0, 0, 16'h0000, 32'h00000000, 1);
    vecs[12] = mk(0, 16'h0017, 8'h99, 0, 1, 2, 8'h00, 0, 0, 16'h0000, 32'h00000000, 0);
    vecs[13] = mk(0, 16'h0018, 8'h11, 0, 0, 4, 8'h00, 1, 0, 16'h0000, 32'h00000000, 1);
    vecs[14] = mk(0, 16'h0019, 8'h22, 0, 1, 2, 8'h00, 0, 0, 16'h0000, 32'h00000000, 0);
    vecs[15] = mk(1, 16'h0018, 8'h00, 0, 1, 2, 8'h11, 0, 0, 16'h0000, 32'h00000000, 0);
    // after the mid-transaction reset: everything is a cold miss
    vecs[16] = mk(1, 16'h0020, 8'h00, 0, 0, 4, 8'h08, 1, 0, 16'h0000, 32'h00000000, 0);
    vecs[17] = mk(1, 16'h0010, 8'h00, 0, 0, 4, 8'hAA, 1, 0, 16'h0000, 32'h00000000, 0);
    vecs[18] = mk(1, 16'h0015, 8'h00, 0, 0, 4, 8'h00, 1, 0, 16'h0000, 32'h00000000, 0);

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst stall", 32'(stall), 32'd0);
    check("rst hit", 32'(hit), 32'd0);
    check("rst miss", 32'(miss), 32'd0);
    check("rst pr_done", 32'(pr_done), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst bus_rd", 32'(bus_rd), 32'd0);
    check("rst bus_upd", 32'(bus_upd), 32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst pr_rdata", 32'(pr_rdata), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int k = 0; k <= 15; k++) run_tx(k);

    // Reset while the fill is on the bus
    pr_req = 1'b1; pr_rnw = 1'b1; pr_addr = 16'h0020; shared = 1'b0;
    @(posedge clock);
    @(negedge clock);
    pr_req = 1'b0;
    check("abort miss in CHECK", 32'(miss), 32'd1);
    @(negedge clock);
    @(negedge clock);
    check("abort bus_rd in RDMEM", 32'(bus_rd), 32'd1);
    we_before = we_total;
    #1 reset = 1'b1;
    #1;
    check("abort stall", 32'(stall), 32'd0);
    check("abort bus_rd", 32'(bus_rd), 32'd0);
    check("abort miss", 32'(miss), 32'd0);
    $display("tx abort: reset during RDMEM stall=%0d bus_rd=%0d", stall, bus_rd);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("abort no writeback", we_total, we_before);

    for (int k = 16; k <= 18; k++) run_tx(k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
